// File: rtl/wb_stage_pkg.sv
// Shared widths and the EXM->WB entry layout for the writeback stage.
package wb_stage_pkg;
   localparam int XLEN            = 32;
   localparam int RF_AW           = 5;
   localparam int ES_TO_WS_BUS_WD = 70;
   localparam int FORWARD_BUS_WD  = 38;
   localparam int CNT_W           = 64;

   // Field order matches the packed bus: gr_we at the top, pc in the low word.
   typedef struct packed {
      logic             gr_we;
      logic [RF_AW-1:0] dest;
      logic [XLEN-1:0]  result;
      logic [XLEN-1:0]  pc;
   } ws_entry_t;
endpackage

// File: rtl/wb_stage_regfile.sv
// 32x32 architectural register file: two async read ports with write-through
// bypass, one synchronous write port, r0 hardwired to zero.
module wb_stage_regfile
   import wb_stage_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             we_i,
   input  logic [RF_AW-1:0] waddr_i,
   input  logic [XLEN-1:0]  wdata_i,
   input  logic [RF_AW-1:0] raddr1_i,
   output logic [XLEN-1:0]  rdata1_o,
   input  logic [RF_AW-1:0] raddr2_i,
   output logic [XLEN-1:0]  rdata2_o
);
   logic [XLEN-1:0] rf_q [2**RF_AW];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 2**RF_AW; i++) rf_q[i] <= '0;
      end else if (we_i && (waddr_i != '0)) begin
         rf_q[waddr_i] <= wdata_i;
      end
   end

   // Bypass lets ID see the value being retired this cycle.
   always_comb begin
      rdata1_o = rf_q[raddr1_i];
      if (raddr1_i == '0)                        rdata1_o = '0;
      else if (we_i && (raddr1_i == waddr_i))    rdata1_o = wdata_i;
   end

   always_comb begin
      rdata2_o = rf_q[raddr2_i];
      if (raddr2_i == '0)                        rdata2_o = '0;
      else if (we_i && (raddr2_i == waddr_i))    rdata2_o = wdata_i;
   end
endmodule

// File: rtl/wb_stage.sv
// Writeback stage: holds the EXM result, retires it into the register file,
// forwards it back to EXM and reports it on the trace/difftest port.
module wb_stage
   import wb_stage_pkg::*;
(
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       es_to_ws_valid,
   input  logic [ES_TO_WS_BUS_WD-1:0] es_to_ws_bus,
   output logic                       ws_ready,
   input  logic                       halt_req,
   input  logic [RF_AW-1:0]           rf_raddr1,
   output logic [XLEN-1:0]            rf_rdata1,
   input  logic [RF_AW-1:0]           rf_raddr2,
   output logic [XLEN-1:0]            rf_rdata2,
   output logic [FORWARD_BUS_WD-1:0]  wb_forward_bus,
   output logic [XLEN-1:0]            debug_wb_pc,
   output logic [3:0]                 debug_wb_rf_we,
   output logic [RF_AW-1:0]           debug_wb_rf_wnum,
   output logic [XLEN-1:0]            debug_wb_rf_wdata,
   output logic [CNT_W-1:0]           retire_cnt
);
   ws_entry_t        bus_q, bus_d;
   logic             valid_q, valid_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             retire;
   logic             rf_we;
   logic             writes_rf;

   assign ws_ready  = ~halt_req;
   assign retire    = valid_q & ws_ready;
   assign writes_rf = bus_q.gr_we & (bus_q.dest != '0);
   assign rf_we     = retire & writes_rf;

   always_comb begin
      valid_d = valid_q;
      bus_d   = bus_q;
      if (ws_ready) begin
         valid_d = es_to_ws_valid;
         bus_d   = ws_entry_t'(es_to_ws_bus);
      end
      cnt_d = cnt_q + CNT_W'(retire);
   end

   // Reset drops any held entry without retiring it.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         bus_q   <= '0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         bus_q   <= bus_d;
         cnt_q   <= cnt_d;
      end
   end

   wb_stage_regfile u_regfile (
      .clk      (clk),
      .reset    (reset),
      .we_i     (rf_we),
      .waddr_i  (bus_q.dest),
      .wdata_i  (bus_q.result),
      .raddr1_i (rf_raddr1),
      .rdata1_o (rf_rdata1),
      .raddr2_i (rf_raddr2),
      .rdata2_o (rf_rdata2)
   );

   // Forward stays asserted through a halt: the value is still the newest one.
   assign wb_forward_bus    = {valid_q & writes_rf, bus_q.dest, bus_q.result};
   assign debug_wb_pc       = valid_q ? bus_q.pc : '0;
   assign debug_wb_rf_we    = {4{rf_we}};
   assign debug_wb_rf_wnum  = bus_q.dest;
   assign debug_wb_rf_wdata = bus_q.result;
   assign retire_cnt        = cnt_q;
endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus randomized traffic
// against an instruction-level reference model.
module tb_wb_stage;
   logic        clk = 1'b0;
   logic        reset;
   logic        es_to_ws_valid;
   logic [69:0] es_to_ws_bus;
   logic        ws_ready;
   logic        halt_req;
   logic [4:0]  rf_raddr1, rf_raddr2;
   logic [31:0] rf_rdata1, rf_rdata2;
   logic [37:0] wb_forward_bus;
   logic [31:0] debug_wb_pc;
   logic [3:0]  debug_wb_rf_we;
   logic [4:0]  debug_wb_rf_wnum;
   logic [31:0] debug_wb_rf_wdata;
   logic [63:0] retire_cnt;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   wb_stage dut (
      .clk(clk), .reset(reset),
      .es_to_ws_valid(es_to_ws_valid), .es_to_ws_bus(es_to_ws_bus),
      .ws_ready(ws_ready), .halt_req(halt_req),
      .rf_raddr1(rf_raddr1), .rf_rdata1(rf_rdata1),
      .rf_raddr2(rf_raddr2), .rf_rdata2(rf_rdata2),
      .wb_forward_bus(wb_forward_bus),
      .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
      .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
      .retire_cnt(retire_cnt)
   );

   // Reference model: the instruction currently sitting in WB, the
   // architectural register contents, and the number retired so far.
   logic        m_valid;
   logic        m_gr_we;
   logic [4:0]  m_dest;
   logic [31:0] m_result, m_pc;
   logic [31:0] m_rf [32];
   logic [63:0] m_cnt;

   function automatic logic m_retiring();
      return m_valid && !halt_req;
   endfunction

   function automatic logic m_writing();
      return m_retiring() && m_gr_we && (m_dest != 5'd0);
   endfunction

   function automatic logic [31:0] exp_rdata(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
      if (m_writing() && a == m_dest) return m_result;
      return m_rf[a];
   endfunction

   function automatic logic [37:0] exp_fwd();
      return {m_valid && m_gr_we && (m_dest != 5'd0), m_dest, m_result};
   endfunction

   function automatic logic [69:0] pack(input logic we, input logic [4:0] d,
                                        input logic [31:0] r, input logic [31:0] pc);
      return {we, d, r, pc};
   endfunction

   // Advance one clock: apply the instruction-level effect of the current
   // inputs to the model, then let the DUT take the same edge.
   task automatic tick();
      if (reset) begin
         m_valid = 0; m_gr_we = 0; m_dest = 0; m_result = 0; m_pc = 0; m_cnt = 0;
         for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
      end else begin
         if (m_writing()) m_rf[m_dest] = m_result;
         if (m_retiring()) m_cnt = m_cnt + 64'd1;
         if (!halt_req) begin
            m_valid = es_to_ws_valid;
            {m_gr_we, m_dest, m_result, m_pc} = es_to_ws_bus;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1; es_to_ws_valid = 0; es_to_ws_bus = '0; halt_req = 0;
      rf_raddr1 = 0; rf_raddr2 = 0;
      tick(); tick();
      reset = 0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (retire_cnt !== 64'd0) begin failures++;
         $display("FAIL reset_cnt actual=%0d required=0", retire_cnt); end
      checks++; if (debug_wb_pc !== 32'd0 || debug_wb_rf_we !== 4'd0) begin failures++;
         $display("FAIL reset_dbg actual pc=%h we=%h required 0/0", debug_wb_pc, debug_wb_rf_we); end
      checks++; if (wb_forward_bus !== 38'd0) begin failures++;
         $display("FAIL reset_fwd actual=%h required=0", wb_forward_bus); end
   endtask

   task automatic test_basic();
      do_reset();
      es_to_ws_valid = 1; es_to_ws_bus = pack(1, 5, 32'hDEADBEEF, 32'h1c000000);
      tick();
      es_to_ws_valid = 0;
      #1;
      checks++; if (debug_wb_rf_we !== 4'hf || debug_wb_rf_wnum !== 5'd5) begin failures++;
         $display("FAIL basic_we actual we=%h wnum=%0d required f/5", debug_wb_rf_we, debug_wb_rf_wnum); end
      checks++; if (debug_wb_pc !== 32'h1c000000 || debug_wb_rf_wdata !== 32'hDEADBEEF) begin failures++;
         $display("FAIL basic_pc actual pc=%h wdata=%h required 1c000000/deadbeef", debug_wb_pc, debug_wb_rf_wdata); end
      tick();
      rf_raddr1 = 5;
      #1;
      checks++; if (rf_rdata1 !== 32'hDEADBEEF) begin failures++;
         $display("FAIL basic_read actual=%h required=deadbeef", rf_rdata1); end
      checks++; if (retire_cnt !== 64'd1) begin failures++;
         $display("FAIL basic_cnt actual=%0d required=1", retire_cnt); end
   endtask

   task automatic test_bypass();
      do_reset();
      es_to_ws_valid = 1; es_to_ws_bus = pack(1, 7, 32'h12345678, 32'h1c000010);
      tick();
      es_to_ws_valid = 0; rf_raddr2 = 7; rf_raddr1 = 6;
      #1;
      checks++; if (rf_rdata2 !== 32'h12345678) begin failures++;
         $display("FAIL bypass_rd2 actual=%h required=12345678", rf_rdata2); end
      checks++; if (rf_rdata1 !== 32'd0) begin failures++;
         $display("FAIL bypass_other actual=%h required=0", rf_rdata1); end
      tick();
   endtask

   task automatic test_r0();
      logic [63:0] c0;
      do_reset();
      c0 = retire_cnt;
      es_to_ws_valid = 1; es_to_ws_bus = pack(1, 0, 32'hFFFFFFFF, 32'h1c000020);
      tick();
      es_to_ws_valid = 0; rf_raddr1 = 0;
      #1;
      checks++; if (debug_wb_rf_we !== 4'h0 || wb_forward_bus[37] !== 1'b0) begin failures++;
         $display("FAIL r0_we actual we=%h fwd_we=%b required 0/0", debug_wb_rf_we, wb_forward_bus[37]); end
      checks++; if (rf_rdata1 !== 32'd0) begin failures++;
         $display("FAIL r0_read actual=%h required=0", rf_rdata1); end
      tick();
      checks++; if (retire_cnt !== c0 + 64'd1 || rf_rdata1 !== 32'd0) begin failures++;
         $display("FAIL r0_cnt actual cnt=%0d rd=%h required %0d/0", retire_cnt, rf_rdata1, c0 + 1); end
   endtask

   task automatic test_halt();
      do_reset();
      es_to_ws_valid = 1; es_to_ws_bus = pack(1, 3, 32'hA5A5_0003, 32'h1c000030);
      tick();
      es_to_ws_valid = 0; halt_req = 1; rf_raddr1 = 3;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (ws_ready !== 1'b0 || debug_wb_rf_we !== 4'h0) begin failures++;
            $display("FAIL halt_ready cyc=%0d actual rdy=%b we=%h required 0/0", i, ws_ready, debug_wb_rf_we); end
         checks++; if (wb_forward_bus !== {1'b1, 5'd3, 32'hA5A5_0003}) begin failures++;
            $display("FAIL halt_fwd cyc=%0d actual=%h required=%h", i, wb_forward_bus, {1'b1, 5'd3, 32'hA5A5_0003}); end
         checks++; if (retire_cnt !== 64'd0 || rf_rdata1 !== 32'd0) begin failures++;
            $display("FAIL halt_hold cyc=%0d actual cnt=%0d rd=%h required 0/0", i, retire_cnt, rf_rdata1); end
         tick();
      end
      halt_req = 0;
      #1;
      checks++; if (debug_wb_rf_we !== 4'hf || ws_ready !== 1'b1) begin failures++;
         $display("FAIL halt_release actual we=%h rdy=%b required f/1", debug_wb_rf_we, ws_ready); end
      tick();
      checks++; if (retire_cnt !== 64'd1 || rf_rdata1 !== 32'hA5A5_0003 || debug_wb_rf_we !== 4'h0) begin failures++;
         $display("FAIL halt_once actual cnt=%0d rd=%h we=%h required 1/a5a50003/0", retire_cnt, rf_rdata1, debug_wb_rf_we); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int i = 1; i <= 4; i++) begin
         es_to_ws_valid = 1; es_to_ws_bus = pack(1, 5'(i), 32'(i * 10), 32'h1c000040 + 32'(4 * i));
         tick();
         checks++; if (debug_wb_rf_we !== 4'hf || debug_wb_rf_wnum !== 5'(i)) begin failures++;
            $display("FAIL b2b_we i=%0d actual we=%h wnum=%0d required f/%0d", i, debug_wb_rf_we, debug_wb_rf_wnum, i); end
      end
      es_to_ws_valid = 0;
      tick();
      checks++; if (retire_cnt !== 64'd4) begin failures++;
         $display("FAIL b2b_cnt actual=%0d required=4", retire_cnt); end
      for (int i = 1; i <= 4; i++) begin
         rf_raddr1 = 5'(i);
         #1;
         checks++; if (rf_rdata1 !== 32'(i * 10)) begin failures++;
            $display("FAIL b2b_rf r%0d actual=%0d required=%0d", i, rf_rdata1, i * 10); end
      end
   endtask

   task automatic test_reset_mid_halt();
      do_reset();
      es_to_ws_valid = 1; es_to_ws_bus = pack(1, 9, 32'h0000_0999, 32'h1c000050);
      tick();
      es_to_ws_valid = 0; halt_req = 1;
      tick();
      reset = 1;
      tick();
      reset = 0; rf_raddr1 = 9;
      #1;
      checks++; if (debug_wb_pc !== 32'd0 || debug_wb_rf_wnum !== 5'd0 || debug_wb_rf_wdata !== 32'd0) begin failures++;
         $display("FAIL rmh_dbg actual pc=%h wnum=%0d wdata=%h required 0", debug_wb_pc, debug_wb_rf_wnum, debug_wb_rf_wdata); end
      halt_req = 0;
      #1;
      checks++; if (debug_wb_rf_we !== 4'h0 || wb_forward_bus !== 38'd0) begin failures++;
         $display("FAIL rmh_we actual we=%h fwd=%h required 0/0", debug_wb_rf_we, wb_forward_bus); end
      tick();
      checks++; if (retire_cnt !== 64'd0 || rf_rdata1 !== 32'd0) begin failures++;
         $display("FAIL rmh_state actual cnt=%0d r9=%h required 0/0", retire_cnt, rf_rdata1); end
   endtask

   task automatic test_random();
      do_reset();
      for (int n = 0; n < 400; n++) begin
         reset          = ($urandom_range(0, 99) == 0);
         halt_req       = ($urandom_range(0, 4) == 0);
         es_to_ws_valid = $urandom_range(0, 3) != 0;
         es_to_ws_bus   = pack(1'($urandom), 5'($urandom_range(0, 7)), $urandom, $urandom);
         rf_raddr1      = 5'($urandom_range(0, 7));
         rf_raddr2      = m_valid ? m_dest : 5'($urandom_range(0, 7));
         #1;
         checks++; if (ws_ready !== !halt_req || debug_wb_rf_we !== {4{m_writing()}}) begin failures++;
            $display("FAIL rnd_ctrl n=%0d actual rdy=%b we=%h required %b/%h", n, ws_ready, debug_wb_rf_we, !halt_req, {4{m_writing()}}); end
         checks++; if (rf_rdata1 !== exp_rdata(rf_raddr1) || rf_rdata2 !== exp_rdata(rf_raddr2)) begin failures++;
            $display("FAIL rnd_read n=%0d actual %h/%h required %h/%h", n, rf_rdata1, rf_rdata2, exp_rdata(rf_raddr1), exp_rdata(rf_raddr2)); end
         checks++; if (wb_forward_bus !== exp_fwd() || debug_wb_pc !== (m_valid ? m_pc : 32'd0)) begin failures++;
            $display("FAIL rnd_fwd n=%0d actual fwd=%h pc=%h required %h/%h", n, wb_forward_bus, debug_wb_pc, exp_fwd(), m_valid ? m_pc : 32'd0); end
         checks++; if (retire_cnt !== m_cnt) begin failures++;
            $display("FAIL rnd_cnt n=%0d actual=%0d required=%0d", n, retire_cnt, m_cnt); end
         tick();
      end
      reset = 0; halt_req = 0; es_to_ws_valid = 0;
      tick(); tick();
      for (int a = 0; a < 8; a++) begin
         rf_raddr1 = 5'(a);
         #1;
         checks++; if (rf_rdata1 !== m_rf[a]) begin failures++;
            $display("FAIL rnd_final r%0d actual=%h required=%h", a, rf_rdata1, m_rf[a]); end
      end
   endtask

   initial begin
      reset = 1; es_to_ws_valid = 0; es_to_ws_bus = '0; halt_req = 0;
      rf_raddr1 = 0; rf_raddr2 = 0;
      test_reset();
      test_basic();
      test_bypass();
      test_r0();
      test_halt();
      test_back_to_back();
      test_reset_mid_halt();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Final pipeline stage. Consumes the EXM→WB bus `{gr_we, dest, result, pc}` and retires each instruction exactly once.
- Owns the 32x32 architectural register file, with two read ports for ID and internal write-through bypass.
- Drives the WB forwarding bus back to EXM.
- Drives the difftest/trace debug port and a 64-bit retired-instruction counter.

Parameters:
- XLEN, 32, datapath width
- RF_AW, 5, register address width (32 entries)
- ES_TO_WS_BUS_WD, 70, incoming bus width: gr_we(1) + dest(5) + result(32) + pc(32)
- FORWARD_BUS_WD, 38, forward bus width: we(1) + dest(5) + data(32)
- CNT_W, 64, retire counter width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- es_to_ws_valid  in  1  EXM output entry valid (registered in EXM)
- es_to_ws_bus  in  70  {gr_we[69], dest[68:64], result[63:32], pc[31:0]}
- ws_ready  out  1  WB can accept a new entry this cycle
- halt_req  in  1  debug/bench hold; freezes retirement
- rf_raddr1  in  5  ID read port 1 address
- rf_rdata1  out  32  ID read port 1 data
- rf_raddr2  in  5  ID read port 2 address
- rf_rdata2  out  32  ID read port 2 data
- wb_forward_bus  out  38  {we[37], dest[36:32], data[31:0]}
- debug_wb_pc  out  32  pc of the retiring instruction
- debug_wb_rf_we  out  4  byte write enables; 4'hf on an RF write, else 0
- debug_wb_rf_wnum  out  5  RF write index
- debug_wb_rf_wdata  out  32  RF write data
- retire_cnt  out  64  instructions retired since reset

Behaviour:
- **Handshake.** `ws_ready = ~halt_req`, purely combinational. Entry register `{ws_valid_r, ws_bus_r}` loads on a posedge when `ws_ready = 1`: `ws_valid_r <= es_to_ws_valid` and `ws_bus_r <= es_to_ws_bus`. When `ws_ready = 0` both hold.
- **Retire condition.** `retire = ws_valid_r & ws_ready`. An entry retires in the first cycle it is held with `halt_req = 0`. Latency is 1 cycle from EXM register to retire; RF updates at the end of that cycle.
- **RF write.** `rf_we = retire & gr_we & (dest != 0)`. Write at posedge: `rf[dest] <= result`. r0 is hardwired 0; writes to it are dropped, but the instruction still retires and counts.
- **RF read.** Combinational.
  - Address 0 returns 0.
  - If `rf_we` is asserted and `raddr == dest`, return `result` (same-cycle bypass).
  - Otherwise return `rf[raddr]`.
- **Forwarding.** `wb_forward_bus = {ws_valid_r & gr_we & (dest != 0), dest, result}`. It stays valid during halt, since the value is not yet in the RF but remains correct.
- **Debug port.**
  - `debug_wb_pc = ws_bus_r pc` whenever `ws_valid_r`, else 0.
  - `debug_wb_rf_we = {4{rf_we}}`.
  - `debug_wb_rf_wnum = dest` and `debug_wb_rf_wdata = result` (don't-care when `we = 0`; drive the latched values).
- **Counter.** `retire_cnt` increments by 1 on each `retire`, including non-writing instructions. It wraps modulo 2^64.
- **Reset** (synchronous, overrides everything including a mid-halt state):
  - `ws_valid_r = 0`, `ws_bus_r = 0`, `retire_cnt = 0`.
  - All 31 RF entries = 0.
  - A held entry is discarded without retiring. Outputs return to 0 on the cycle after reset is sampled.
- **Simultaneous events.**
  - A new entry arriving while the current one retires: both happen in the same cycle (back-to-back throughput of 1/cycle).
  - `halt_req` rising while an entry is valid: no retire, no RF write, no count until `halt_req` falls.
- No exceptions/CSR in this block; none are carried on the incoming bus.

Decomposition:
- Shared define header (existing `define.vh`) holds the bus widths `ES_TO_WS_BUS_WD` and `FORWAED_BUS_WD` and the field bit positions (we = 37, dest = 36:32).
- One sub-module: `regfile` (32x32, 2 async read ports, 1 sync write port, r0 = 0, write-through bypass).
- Stage register, retire logic, counter and debug port stay in `wb_stage`.

Test Plan:
1. Reset, then one entry `{gr_we=1, dest=5, result=32'hDEADBEEF, pc=32'h1c000000}`. Required next cycle:
   - `debug_wb_rf_we = 4'hf`, `wnum = 5`, `debug_wb_pc = 32'h1c000000`.
   - Following cycle: `rf_raddr1 = 5` reads `32'hDEADBEEF`; `retire_cnt = 1`.
2. Bypass: while entry `dest=7, result=32'h12345678` retires, drive `rf_raddr2 = 7` → `rf_rdata2 = 32'h12345678` in the same cycle (RF previously held 0).
3. r0: entry `gr_we=1, dest=0, result=32'hFFFFFFFF` → `debug_wb_rf_we = 0`, forward `we = 0`, `rf_raddr1 = 0` reads 0, `retire_cnt` increments.
4. Halt: entry `dest=3` valid, hold `halt_req = 1` for 3 cycles.
   - During halt: `ws_ready = 0`, no RF write, counter unchanged, forward bus = `{1, 3, data}` steady.
   - On release: exactly one write and one increment.
5. Back-to-back: 4 consecutive valid entries, `dest = 1..4`, `result = 10..40` → four consecutive cycles with `rf_we = 1`, `retire_cnt = 4`, each RF entry correct.
6. Reset mid-halt: entry `dest=9` valid, `halt_req = 1`, assert `reset` → `rf[9]` stays 0, `retire_cnt = 0`, `ws_valid_r = 0`, debug outputs 0.
